// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: hex font, blank pattern, DP bit.
// Segment patterns are active-low. Bit 7 is the decimal point.
// FONT is indexed by the digit value: FONT[4'hA] is the pattern for 'A'.
package seg_scan_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam int         DP_BIT  = 7;

   // Packed so that FONT[n] selects the pattern for nibble n (entry 15 is written first).
   localparam logic [15:0][7:0] FONT = {
      8'h93, 8'h92, 8'hE0, 8'hF2,   // F E D C
      8'hD0, 8'hA0, 8'h84, 8'h80,   // B A 9 8
      8'hAD, 8'h90, 8'h94, 8'hC5,   // 7 6 5 4
      8'hA4, 8'hA2, 8'hED, 8'h88    // 3 2 1 0
   };

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex-nibble to seven-segment pattern lookup. The DP bit is left off (high).
// Ports: nibble (4-bit digit value) -> pattern (8-bit active-low segments).
// Zero latency: this is a pure table lookup with no registers.
module seg_hex_font
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] pattern
);

   assign pattern = FONT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with a prescaler, PWM brightness and double-buffered data.
// Ports: clk/rst; digits, dp_en, blank and load feed the shadow set; brightness is sampled live.
// Outputs: sel/seg are active-low. frame_done pulses once per frame. Outputs are registered one cycle after slot/pwm_cnt.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 10000,
   parameter int PWM_BITS   = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_en,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [PWM_BITS-1:0]     brightness,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   sel,
   output logic [7:0]              seg,
   output logic                    frame_done
);

   localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PS_W-1:0]         presc;
   logic [PWM_BITS-1:0]     pwm_cnt;
   logic [SL_W-1:0]         slot;
   logic                    tick;
   logic                    slot_adv;
   logic                    boundary;

   logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
   logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
   logic                    dirty;

   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [7:0]              font_pat;
   logic [7:0]              seg_nxt;
   logic [NUM_DIGITS-1:0]   sel_nxt;
   logic                    lit;

   assign tick     = (presc == PS_W'(CLK_DIV - 1));
   assign slot_adv = tick && (&pwm_cnt);
   assign boundary = slot_adv && (slot == SL_W'(NUM_DIGITS - 1));

   // Timebase: prescaler -> PWM phase -> digit slot. The slot wraps explicitly, so NUM_DIGITS
   // need not be a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         pwm_cnt <= '0;
         slot    <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
         if (slot_adv)
            slot <= boundary ? '0 : slot + 1'b1;
      end
   end

   // Double buffering. On a boundary the active set takes the pre-edge shadow. A load in the
   // same cycle refills the shadow and keeps dirty set, so its data waits one more frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_digits  <= '0;
         sh_dp      <= '0;
         sh_blank   <= '1;
         act_digits <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         dirty      <= 1'b0;
      end else begin
         if (boundary && dirty) begin
            act_digits <= sh_digits;
            act_dp     <= sh_dp;
            act_blank  <= sh_blank;
            dirty      <= 1'b0;
         end
         if (load) begin
            sh_digits <= digits;
            sh_dp     <= dp_en;
            sh_blank  <= blank;
            dirty     <= 1'b1;
         end
      end
   end

   always_comb begin
      cur_nib   = act_digits[4*int'(slot) +: 4];
      cur_dp    = act_dp[slot];
      cur_blank = act_blank[slot];
   end

   seg_hex_font u_font (
      .nibble  (cur_nib),
      .pattern (font_pat)
   );

   // sel and seg are computed together and registered together, so a slot change can never
   // briefly drive two digits.
   always_comb begin
      lit     = !cur_blank && (pwm_cnt <= brightness);
      sel_nxt = '1;
      seg_nxt = SEG_OFF;
      if (lit) begin
         sel_nxt = ~(NUM_DIGITS'(1) << slot);
         seg_nxt = font_pat;
         if (cur_dp)
            seg_nxt[DP_BIT] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel        <= '1;
         seg        <= SEG_OFF;
         frame_done <= 1'b0;
      end else begin
         sel        <= sel_nxt;
         seg        <= seg_nxt;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, CLK_DIV=3, PWM_BITS=2).
// Expected outputs are predicted from edge counts since reset release and queued per clock edge.
// Spot checks cover the reset state, the decimal point, PWM duty, a boundary-cycle load and an async reset.
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int CD    = 3;
   localparam int PB    = 2;
   localparam int SLOT  = CD * (1 << PB);
   localparam int FRAME = SLOT * ND;

   logic            clk = 1'b0;
   logic            rst;
   logic [4*ND-1:0] digits;
   logic [ND-1:0]   dp_en;
   logic [ND-1:0]   blank;
   logic [PB-1:0]   brightness;
   logic            load;
   logic [ND-1:0]   sel;
   logic [7:0]      seg;
   logic            frame_done;

   int checks   = 0;
   int failures = 0;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .PWM_BITS(PB)) dut (
      .clk        (clk),
      .rst        (rst),
      .digits     (digits),
      .dp_en      (dp_en),
      .blank      (blank),
      .brightness (brightness),
      .load       (load),
      .sel        (sel),
      .seg        (seg),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] font_ref(input logic [3:0] n);
      case (n)
         4'h0: return 8'h88;  4'h1: return 8'hED;  4'h2: return 8'hA2;  4'h3: return 8'hA4;
         4'h4: return 8'hC5;  4'h5: return 8'h94;  4'h6: return 8'h90;  4'h7: return 8'hAD;
         4'h8: return 8'h80;  4'h9: return 8'h84;  4'hA: return 8'hA0;  4'hB: return 8'hD0;
         4'hC: return 8'hF2;  4'hD: return 8'hE0;  4'hE: return 8'h92;  default: return 8'h93;
      endcase
   endfunction

   // Reference prediction: after edge k (counted from reset release), the outputs reflect
   // timebase state m=k-1. That state is pwm=(m/CD)%4 and slot=(m/SLOT)%ND.
   int              mdl_k;
   logic [4*ND-1:0] m_sh_dig, m_act_dig;
   logic [ND-1:0]   m_sh_dp, m_act_dp, m_sh_blank, m_act_blank;
   logic            m_dirty;
   logic [12:0]     exp_q[$];

   always @(posedge clk or negedge rst) begin
      int          m, sl, pw;
      logic [3:0]  esel;
      logic [7:0]  eseg;
      if (!rst) begin
         mdl_k       = 0;
         m_sh_dig    = '0;  m_act_dig   = '0;
         m_sh_dp     = '0;  m_act_dp    = '0;
         m_sh_blank  = '1;  m_act_blank = '1;
         m_dirty     = 1'b0;
         exp_q.delete();
      end else begin
         m     = mdl_k;
         mdl_k = mdl_k + 1;
         sl    = (m / SLOT) % ND;
         pw    = (m / CD) % (1 << PB);
         esel  = 4'hF;
         eseg  = 8'hFF;
         if (!m_act_blank[sl] && pw <= int'(brightness)) begin
            esel = ~(4'b0001 << sl);
            eseg = font_ref(m_act_dig[sl*4 +: 4]);
            if (m_act_dp[sl]) eseg[7] = 1'b0;
         end
         exp_q.push_back({(mdl_k % FRAME == 0), esel, eseg});
         if ((mdl_k % FRAME == 0) && m_dirty) begin
            m_act_dig   = m_sh_dig;
            m_act_dp    = m_sh_dp;
            m_act_blank = m_sh_blank;
            m_dirty     = 1'b0;
         end
         if (load) begin
            m_sh_dig   = digits;
            m_sh_dp    = dp_en;
            m_sh_blank = blank;
            m_dirty    = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [12:0] e;
      if (rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val("scan", {19'd0, frame_done, sel, seg}, {19'd0, e});
      end
   end

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      digits = d;
      dp_en  = dp;
      blank  = bl;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   // Advance at least one cycle and stop once the model's edge count satisfies mdl_k % FRAME == ph.
   task automatic wait_k(input int ph);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((mdl_k % FRAME != ph) && n < 2 * FRAME);
      if (mdl_k % FRAME != ph) check_val("wait_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      load       = 1'b0;
      digits     = '0;
      dp_en      = '0;
      blank      = '1;
      brightness = 2'd3;
      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_sel", {28'd0, sel}, 32'hF);
      check_val("rst_seg", {24'd0, seg}, 32'hFF);
      check_val("rst_fd", {31'd0, frame_done}, 32'd0);
      rst = 1'b1;

      // Dark after reset release, frame_done every FRAME cycles
      repeat (200) @(negedge clk);

      do_load(16'h3210, 4'b0000, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);
      wait_k(13);
      check_val("slot1_sel", {28'd0, sel}, 32'hD);
      check_val("slot1_seg", {24'd0, seg}, 32'hED);

      do_load(16'h3210, 4'b0010, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);
      wait_k(13);
      check_val("dp_seg", {24'd0, seg}, 32'h6D);

      brightness = 2'd1;
      wait_k(16);
      check_val("pwm_lit_sel", {28'd0, sel}, 32'hD);
      wait_k(19);
      check_val("pwm_dark_sel", {28'd0, sel}, 32'hF);
      check_val("pwm_dark_seg", {24'd0, seg}, 32'hFF);
      repeat (FRAME) @(negedge clk);
      brightness = 2'd3;

      // Load on the boundary cycle itself
      wait_k(5);
      do_load(16'h3210, 4'b0000, 4'b0000);
      wait_k(FRAME - 1);
      do_load(16'hFFFF, 4'b0000, 4'b0000);
      check_val("bnd_fd", {31'd0, frame_done}, 32'd1);
      @(negedge clk);
      check_val("bnd_old_seg", {24'd0, seg}, 32'h88);
      wait_k(1);
      check_val("bnd_new_seg", {24'd0, seg}, 32'h93);
      check_val("bnd_new_sel", {28'd0, sel}, 32'hE);

      // Asynchronous reset in the middle of slot 2
      wait_k(30);
      #2 rst = 1'b0;
      #1;
      check_val("arst_sel", {28'd0, sel}, 32'hF);
      check_val("arst_seg", {24'd0, seg}, 32'hFF);
      check_val("arst_fd", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (100) @(negedge clk);
      check_val("post_rst_dark", {28'd0, sel}, 32'hF);
      do_load(16'h3210, 4'b0000, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
